// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants for the 7-segment scan driver.
//   N_DIGITS  number of multiplexed digits
//   SEG_OFF   all segments dark (active-low)
//   AN_OFF    no digit selected (active-low)
//   HEX_SEG   active-low a..g codes for hex 0..F, bit 0 = a
//   lz_dark() leading-zero suppression test for one digit
package sseg_pkg;

    localparam int unsigned N_DIGITS = 4;
    localparam logic [7:0]  SEG_OFF  = 8'hFF;
    localparam logic [3:0]  AN_OFF   = 4'hF;

    // Indexed by nibble value; entry 15 is listed first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // A digit is dark under suppression when it and every higher nibble are zero.
    // Digit 0 always shows, so a zero value still reads "0".
    function automatic logic lz_dark(input logic [15:0] value, input logic [1:0] digit,
                                     input logic lz);
        logic dark;
        dark = lz && (digit != 2'd0);
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (i >= int'(digit) && value[i*4 +: 4] != 4'h0) begin
                dark = 1'b0;
            end
        end
        return dark;
    endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// sseg_scan_driver_if: display request from the calculator core and the
// resulting board-level drive.
//   data[15:0]  four hex nibbles, data[3:0] = rightmost digit
//   dp[3:0]     decimal point per digit, 1 = lit
//   blank[3:0]  per-digit force-off, 1 = dark
//   lz_en       leading-zero suppression enable
//   AN[3:0]     digit enables, active-low
//   SEG[7:0]    segments a..g + dp, active-low
//   frame       one-cycle pulse at the start of each scan frame
// master = core side, slave = scan driver.
interface sseg_scan_driver_if;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic [3:0]  AN;
    logic [7:0]  SEG;
    logic        frame;

    modport master (
        output data, dp, blank, lz_en,
        input  AN, SEG, frame
    );

    modport slave (
        input  data, dp, blank, lz_en,
        output AN, SEG, frame
    );
endinterface

// File: rtl/hex2seg.sv
// hex2seg: combinational hex nibble to 7-segment decoder.
//   nib[3:0]  hex value
//   seg[6:0]  active-low segments, seg[0] = a .. seg[6] = g
module hex2seg
    import sseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed driver for a 4-digit common-anode display.
// Inputs are captured into shadow registers once per frame so a frame never
// mixes old and new values; AN/SEG/frame are driven straight from flops.
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   bus    sseg_scan_driver_if.slave (data/dp/blank/lz_en in, AN/SEG/frame out)
// PRESCALE clk cycles per digit slot; CNT_W must satisfy 2**CNT_W >= PRESCALE.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic                clk,
    input  logic                rst,
    sseg_scan_driver_if.slave   bus
);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             first;    // set by reset so the first tick lands on digit 0
    logic             tick;
    logic [1:0]       idx_next;
    logic             load;

    logic [15:0] sh_data;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_blank;
    logic        sh_lz;

    logic [15:0] cur_data;
    logic [3:0]  cur_dp;
    logic [3:0]  cur_blank;
    logic        cur_lz;
    logic [3:0]  cur_nib;
    logic [6:0]  seg7;
    logic        digit_off;
    logic [3:0]  an_next;
    logic [7:0]  seg_next;

    logic [3:0]  an_q;
    logic [7:0]  seg_q;
    logic        frame_q;

    assign tick     = (cnt == CNT_W'(PRESCALE - 1));
    assign idx_next = first ? 2'd0 : idx + 2'd1;
    assign load     = tick && (idx_next == 2'd0);

    // On a frame-start tick the shadow is loading this very edge, so decode the
    // live inputs to keep the first digit consistent with the rest of the frame.
    always_comb begin
        cur_data  = sh_data;
        cur_dp    = sh_dp;
        cur_blank = sh_blank;
        cur_lz    = sh_lz;
        if (load) begin
            cur_data  = bus.data;
            cur_dp    = bus.dp;
            cur_blank = bus.blank;
            cur_lz    = bus.lz_en;
        end
    end

    assign cur_nib = cur_data[idx_next*4 +: 4];

    hex2seg u_hex2seg (
        .nib (cur_nib),
        .seg (seg7)
    );

    always_comb begin
        digit_off = cur_blank[idx_next] || lz_dark(cur_data, idx_next, cur_lz);
        an_next   = ~(4'b0001 << idx_next);
        seg_next  = digit_off ? SEG_OFF : {~cur_dp[idx_next], seg7};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= 2'd0;
            first    <= 1'b1;
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            frame_q  <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + CNT_W'(1);
            frame_q <= load;
            if (tick) begin
                idx   <= idx_next;
                first <= 1'b0;
                an_q  <= an_next;
                seg_q <= seg_next;
            end
            if (load) begin
                sh_data  <= bus.data;
                sh_dp    <= bus.dp;
                sh_blank <= bus.blank;
                sh_lz    <= bus.lz_en;
            end
        end
    end

    assign bus.AN    = an_q;
    assign bus.SEG   = seg_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
module tb_sseg_scan_driver;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned CNT_W    = 3;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       frame;
    } exp_t;

    logic clk;
    logic rst;
    sseg_scan_driver_if bus ();

    exp_t q[$];
    int   n_cmp;
    int   n_fail;

    sseg_scan_driver #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) begin
            q.push_back('{an: 4'hF, seg: 8'hFF, frame: 1'b0});
        end
    endtask

    // Expected scan of one full frame: digits 0..3, each held PRESCALE cycles.
    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] s [4];
        logic [3:0] an;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            an = ~(4'b0001 << d);
            for (int k = 0; k < int'(PRESCALE); k++) begin
                q.push_back('{an: an, seg: s[d], frame: (d == 0 && k == 0)});
            end
        end
    endtask

    task automatic drain(input int n, input string tag);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $error("FAIL %s queue empty at step %0d", tag, k);
            end else begin
                e = q.pop_front();
                assert ({bus.AN, bus.SEG, bus.frame} === {e.an, e.seg, e.frame})
                else begin
                    n_fail++;
                    $error("FAIL %s[%0d] AN/SEG/frame got %b/%h/%b want %b/%h/%b",
                           tag, k, bus.AN, bus.SEG, bus.frame, e.an, e.seg, e.frame);
                end
            end
        end
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                          input logic lz);
        bus.data  = d;
        bus.dp    = p;
        bus.blank = b;
        bus.lz_en = lz;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        set_in(16'h1234, 4'b0000, 4'b0000, 1'b0);

        // Held reset: outputs dark.
        push_idle(10);
        drain(10, "reset_hold");
        rst = 1'b0;

        // Dark until the first tick, then two frames of 1234.
        push_idle(PRESCALE - 1);
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        drain(PRESCALE - 1 + 16, "f1234_a");
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        drain(16, "f1234_b");

        // Leading-zero suppression on and off.
        set_in(16'h00A0, 4'b0000, 4'b0000, 1'b1);
        push_frame(8'hC0, 8'h88, 8'hFF, 8'hFF);
        drain(16, "lz_on");
        set_in(16'h00A0, 4'b0000, 4'b0000, 1'b0);
        push_frame(8'hC0, 8'h88, 8'hC0, 8'hC0);
        drain(16, "lz_off");

        // All zero with suppression: only digit 0 lit, with its dp.
        set_in(16'h0000, 4'b0001, 4'b0000, 1'b1);
        push_frame(8'h40, 8'hFF, 8'hFF, 8'hFF);
        drain(16, "zero_dp");

        // Blanked digit hides its dp too.
        set_in(16'h8888, 4'b0100, 4'b0100, 1'b0);
        push_frame(8'h80, 8'h80, 8'hFF, 8'h80);
        drain(16, "blank");

        // Input change mid-frame stays invisible until the next frame.
        set_in(16'h1234, 4'b0000, 4'b0000, 1'b0);
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        drain(10, "midchg_pre");
        bus.data = 16'hABCD;
        drain(6, "midchg_post");
        push_frame(8'hA1, 8'hC6, 8'h83, 8'h88);
        drain(16, "fabcd");

        // One-cycle reset while digit 3 is shown restarts the scan.
        push_frame(8'hA1, 8'hC6, 8'h83, 8'h88);
        drain(13, "pre_rst");
        q.delete();
        rst = 1'b1;
        push_idle(1);
        drain(1, "mid_rst");
        rst = 1'b0;
        push_idle(PRESCALE - 1);
        push_frame(8'hA1, 8'hC6, 8'h83, 8'h88);
        drain(PRESCALE - 1 + 16, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Time-multiplexed driver for the 4-digit, common-anode 7-segment display on the lab board.
- Sits directly downstream of the calculator core: takes the 16-bit result as four hex nibbles, plus per-digit decimal-point and blank masks.
- Drives AN/SEG with a registered, glitch-free scan.
- Latches a shadow copy of the inputs once per scan frame, so a displayed frame never mixes old and new values.

Parameters:
- PRESCALE, 50000, clk cycles per digit slot. Legal range 2..2^20; 50000 at 50 MHz gives a 1 kHz digit rate / 250 Hz frame rate.
- CNT_W, 20, prescaler counter width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
- clk     in   1   system clock, rising edge
- rst     in   1   synchronous, active-high reset
- data    in   16  value to display; data[3:0] = digit 0 (rightmost), data[15:12] = digit 3
- dp      in   4   decimal-point enable per digit, 1 = lit
- blank   in   4   per-digit force-off, 1 = digit dark
- lz_en   in   1   leading-zero suppression enable
- AN      out  4   digit enables, active-low, AN[i] selects digit i
- SEG     out  8   segments, active-low; SEG[0..6] = a..g, SEG[7] = dp
- frame   out  1   one-cycle pulse when the shadow registers load (frame start)

Behaviour:
- Reset (rst=1 at a clk edge):
  - prescaler cnt = 0, digit index idx = 0.
  - Shadow registers = 0.
  - AN = 4'b1111, SEG = 8'hFF, frame = 0.
  - Reset mid-scan behaves identically; there is no partial-frame carry-over.
- Prescaler:
  - cnt increments each cycle.
  - tick = (cnt == PRESCALE-1); cnt returns to 0 on tick.
- Index:
  - On tick, idx <= idx+1 mod 4 (3 wraps to 0).
  - The first tick after reset selects idx 0.
  - A reset flag forces the first tick to load idx 0 rather than increment.
- Shadow load:
  - On any tick whose new idx is 0, sh_data/sh_dp/sh_blank/sh_lz are loaded from the inputs.
  - frame = 1 in that same cycle.
  - Input changes at any other time are invisible until the next frame.
- Output register:
  - On each tick, AN and SEG are updated together for the new idx, using the values just loaded when idx = 0.
  - AN = ~(4'b0001 << idx).
  - Latency: AN/SEG change exactly 1 clk after the tick cycle. The first valid digit appears PRESCALE+1 cycles after rst deasserts.
- Digit off conditions. A digit is off (AN bit stays 0 as selected, SEG = 8'hFF, dp also off) if either:
  - sh_blank[idx] = 1, or
  - it is leading-zero suppressed.
- Leading-zero suppression:
  - Applies when sh_lz = 1.
  - Digit i (i = 3..1) is suppressed if its nibble and all higher nibbles are 0.
  - Digit 0 is never suppressed (value 0 shows "0").
  - A suppressed digit's dp is also dark.
- Decode (SEG[6:0], active-low), hex 0..F:
  C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E
  (values are with bit7 = 1).
- SEG[7] = ~dp of the current digit when the digit is not off.
- Outputs are purely registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package sseg_pkg:
  - N_DIGITS = 4.
  - SEG_OFF = 8'hFF.
  - AN_OFF = 4'hF.
  - 16-entry hex segment code constant table.
- Sub-module hex2seg: combinational, 4-bit nibble in, 7-bit active-low segments out.
- Everything else is in sseg_scan_driver.

Test Plan (PRESCALE=4 for simulation):
- Reset hold 10 cycles, then release with data=16'h1234, dp=0, blank=0, lz_en=0:
  - AN=1111 and SEG=FF until the first tick.
  - Then AN sequence 1110,1101,1011,0111 with SEG 99,B0,A4,F9, each held 4 clk.
  - frame pulses every 16 clk.
- data=16'h00A0, lz_en=1:
  - Digits 3,2 dark (SEG=FF).
  - Digit 1 shows 88, digit 0 shows C0.
  - With lz_en=0: digits 3,2 show C0.
- data=16'h0000, lz_en=1, dp=4'b0001:
  - Only digit 0 lit, SEG=40 (0 with dp).
  - Digits 1..3 SEG=FF.
- blank=4'b0100, data=16'h8888, dp=4'b0100:
  - Digit 2 SEG=FF (dp suppressed).
  - Other digits SEG=80.
- Change data from 1234 to ABCD while idx=2 is displayed:
  - Digits 2 and 3 of this frame still show A4/F9.
  - The next frame shows 83(B... d0=D: A1), i.e. sequence A1,C6,83,88.
  - frame marks the switch.
- Assert rst for 1 cycle while idx=3:
  - Next edge AN=1111, SEG=FF.
  - The scan restarts at idx 0 after PRESCALE+1 cycles.
